// File: rtl/moving_avg_filter_if.sv
// Sample-stream interface for moving_avg_filter.
//   master : sample source (drives i_clr, i_valid, i_data; observes results)
//   slave  : the filter (consumes samples, drives o_valid, o_sum, o_avg, o_full)
// Signals:
//   i_clr    sync clear of window/accumulator
//   i_valid  i_data accepted this cycle
//   i_data   WIDTH-bit unsigned sample
//   o_valid  1-cycle pulse: o_sum/o_avg updated
//   o_sum    sum of last DEPTH accepted samples (WIDTH+log2(DEPTH) bits)
//   o_avg    o_sum / DEPTH
//   o_full   DEPTH samples accepted since reset/clear
interface moving_avg_filter_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    localparam int YWD = WIDTH + $clog2(DEPTH);

    logic             i_clr;
    logic             i_valid;
    logic [WIDTH-1:0] i_data;
    logic             o_valid;
    logic [YWD-1:0]   o_sum;
    logic [WIDTH-1:0] o_avg;
    logic             o_full;

    modport master (
        output i_clr, i_valid, i_data,
        input  o_valid, o_sum, o_avg, o_full
    );

    modport slave (
        input  i_clr, i_valid, i_data,
        output o_valid, o_sum, o_avg, o_full
    );
endinterface

// File: rtl/moving_avg_filter.sv
// Streaming moving-sum / moving-average over the last DEPTH accepted samples.
// A circular sample buffer plus a running accumulator (add newest, subtract
// evicted) keeps the datapath at a constant number of adders.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    moving_avg_filter_if.slave (i_clr, i_valid, i_data -> o_valid,
//          o_sum, o_avg, o_full)
// Parameters: WIDTH (sample width), DEPTH (window, power of two >= 2).
// Build option: define MAVG_ROUND_EN for round-half-up o_avg; otherwise
// o_avg is truncated. o_sum is identical in both builds.
module moving_avg_filter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    moving_avg_filter_if.slave  bus
);
    localparam int LOG2D = $clog2(DEPTH);
    localparam int YWD   = WIDTH + LOG2D;
    localparam logic [LOG2D:0] FULL_CNT = (LOG2D + 1)'(DEPTH);
`ifdef MAVG_ROUND_EN
    localparam logic [YWD-1:0] HALF = YWD'(DEPTH / 2);
`endif

    logic [WIDTH-1:0] sample_buf [DEPTH];
    logic [LOG2D-1:0] wr_ptr;
    logic [LOG2D:0]   fill_cnt;
    logic [YWD-1:0]   acc;
    logic             o_valid_q;
    logic [WIDTH-1:0] o_avg_q;
    logic             o_full_q;

    logic [YWD-1:0]   acc_next;
    logic [LOG2D:0]   cnt_next;
    logic [WIDTH-1:0] avg_next;

    always_comb begin
        // Modular arithmetic: the evicted sample is always part of acc,
        // so the final result never underflows.
        acc_next = acc + YWD'(bus.i_data) - YWD'(sample_buf[wr_ptr]);
        cnt_next = (fill_cnt == FULL_CNT) ? fill_cnt : fill_cnt + (LOG2D + 1)'(1);
`ifdef MAVG_ROUND_EN
        avg_next = WIDTH'((acc_next + HALF) >> LOG2D);
`else
        avg_next = WIDTH'(acc_next >> LOG2D);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_buf <= '{default: '0};
            wr_ptr     <= '0;
            fill_cnt   <= '0;
            acc        <= '0;
            o_valid_q  <= 1'b0;
            o_avg_q    <= '0;
            o_full_q   <= 1'b0;
        end else if (bus.i_clr) begin
            // Clear wins over a simultaneous sample, which is dropped.
            sample_buf <= '{default: '0};
            wr_ptr     <= '0;
            fill_cnt   <= '0;
            acc        <= '0;
            o_valid_q  <= 1'b0;
            o_avg_q    <= '0;
            o_full_q   <= 1'b0;
        end else if (bus.i_valid) begin
            sample_buf[wr_ptr] <= bus.i_data;
            wr_ptr             <= wr_ptr + LOG2D'(1);  // DEPTH is a power of two: natural wrap
            fill_cnt           <= cnt_next;
            acc                <= acc_next;
            o_valid_q          <= 1'b1;
            o_avg_q            <= avg_next;
            o_full_q           <= (cnt_next == FULL_CNT);
        end else begin
            o_valid_q <= 1'b0;
        end
    end

    // acc is only ever updated alongside the output strobe, so it doubles
    // as the registered o_sum.
    assign bus.o_valid = o_valid_q;
    assign bus.o_sum   = acc;
    assign bus.o_avg   = o_avg_q;
    assign bus.o_full  = o_full_q;
endmodule

// File: tb/tb_moving_avg_filter.sv
// Self-checking bench for moving_avg_filter (WIDTH=8, DEPTH=8).
// Every driven cycle pushes the expected next-cycle outputs into a queue;
// a monitor pops one entry per cycle just after the rising edge.
module tb_moving_avg_filter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    moving_avg_filter_if #(.WIDTH(8), .DEPTH(8)) bus ();

    moving_avg_filter #(.WIDTH(8), .DEPTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic vld;
        int   sum;
        int   avg;
        logic full;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int checks   = 0;
    int failures = 0;

    int mdl_buf [8];
    int mdl_ptr;
    int mdl_cnt;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int mdl_sum();
        int s = 0;
        for (int i = 0; i < 8; i++) s += mdl_buf[i];
        return s;
    endfunction

    function automatic int exp_avg(input int s);
`ifdef MAVG_ROUND_EN
        return (s + 4) / 8;
`else
        return s / 8;
`endif
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < 8; i++) mdl_buf[i] = 0;
        mdl_ptr = 0;
        mdl_cnt = 0;
    endtask

    // Drive one cycle of stimulus and record the outputs expected after it.
    task automatic drive(input logic v, input int d, input logic c);
        exp_t e;
        @(negedge clk);
        bus.i_valid = v;
        bus.i_data  = 8'(d);
        bus.i_clr   = c;
        if (c) begin
            mdl_reset();
            e.vld = 1'b0;
        end else if (v) begin
            mdl_buf[mdl_ptr] = d & 255;
            mdl_ptr = (mdl_ptr + 1) % 8;
            if (mdl_cnt < 8) mdl_cnt++;
            e.vld = 1'b1;
        end else begin
            e.vld = 1'b0;
        end
        e.sum  = mdl_sum();
        e.avg  = exp_avg(e.sum);
        e.full = (mdl_cnt == 8);
        sb_q.push_back(e);
    endtask

    task automatic drain();
        drive(1'b0, 0, 1'b0);
        @(posedge clk);
        #2;
        check("sb_drain", sb_q.size(), 0);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check("o_valid", int'(bus.o_valid), int'(mon_e.vld));
            check("o_sum",   int'(bus.o_sum),   mon_e.sum);
            check("o_avg",   int'(bus.o_avg),   mon_e.avg);
            check("o_full",  int'(bus.o_full),  int'(mon_e.full));
        end
    end

    initial begin
        bus.i_clr   = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        mdl_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check("rst_valid", int'(bus.o_valid), 0);
        check("rst_sum",   int'(bus.o_sum),   0);
        check("rst_avg",   int'(bus.o_avg),   0);
        check("rst_full",  int'(bus.o_full),  0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: fill with 10s
        for (int i = 0; i < 8; i++) drive(1'b1, 10, 1'b0);
        drain();
        check("t1_sum",  int'(bus.o_sum),  80);
        check("t1_full", int'(bus.o_full), 1);

        // 2: eviction and pointer wrap
        drive(1'b1, 26, 1'b0);
        drain();
        check("t2_sum96", int'(bus.o_sum), 96);
        check("t2_avg12", int'(bus.o_avg), 12);
        for (int i = 0; i < 7; i++) drive(1'b1, 26, 1'b0);
        drain();
        check("t2_sum208", int'(bus.o_sum), 208);
        check("t2_avg26",  int'(bus.o_avg), 26);

        // 3: full-scale samples
        for (int i = 0; i < 8; i++) drive(1'b1, 255, 1'b0);
        drain();
        check("t3_sum2040", int'(bus.o_sum), 2040);
        check("t3_avg255",  int'(bus.o_avg), 255);
        drive(1'b1, 0, 1'b0);
        drain();
        check("t3_sum1785", int'(bus.o_sum), 1785);

        // 4: random valid gaps
        for (int i = 0; i < 60; i++)
            drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)), 1'b0);
        drain();

        // 5: clear beats a simultaneous sample
        drive(1'b1, 50, 1'b1);
        drain();
        check("t5_sum0",  int'(bus.o_sum),  0);
        check("t5_full0", int'(bus.o_full), 0);
        drive(1'b1, 7, 1'b0);
        drain();
        check("t5_sum7", int'(bus.o_sum), 7);

        // 6: truncation vs rounding at small sums
        drive(1'b0, 0, 1'b1);
        drive(1'b1, 4, 1'b0);
        drain();
        check("t6_sum4", int'(bus.o_sum), 4);
`ifdef MAVG_ROUND_EN
        check("t6_avg4", int'(bus.o_avg), 1);
`else
        check("t6_avg4", int'(bus.o_avg), 0);
`endif
        drive(1'b0, 0, 1'b1);
        drive(1'b1, 3, 1'b0);
        drain();
        check("t6_avg3", int'(bus.o_avg), 0);

        // Asynchronous reset while a result is being presented
        for (int i = 0; i < 4; i++) drive(1'b1, 100 + i, 1'b0);
        @(posedge clk);
        #2;
        check("mid_valid_before", int'(bus.o_valid), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", int'(bus.o_valid), 0);
        check("mid_rst_sum",   int'(bus.o_sum),   0);
        check("mid_rst_avg",   int'(bus.o_avg),   0);
        check("mid_rst_full",  int'(bus.o_full),  0);
        check("mid_rst_sb",    sb_q.size(),       0);
        mdl_reset();
        @(negedge clk);
        bus.i_valid = 1'b0;
        rst_n = 1'b1;
        drive(1'b1, 5, 1'b0);
        drain();
        check("post_rst_sum5", int'(bus.o_sum), 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
